// File: rtl/pic_8259a_core.sv
`default_nettype none
// ============================================================================
// Module   : pic_8259a_core
// Purpose  : Clocked 8259A-compatible interrupt controller. 8 request inputs,
//            fixed-priority resolution (optional rotate-in-AEOI), 8086-mode
//            two-pulse INTA vectoring, master/slave cascade over cas[2:0].
// Ports    : clk, rst            clock, synchronous active-high reset
//            cs_n, rd_n, wr_n, a0 register access strobes / address
//            sp_en_n             1 = master, 0 = slave
//            inta_n              shared interrupt acknowledge
//            ir[7:0]             requests, ir[0] highest fixed priority
//            data[7:0]           bidirectional data bus (read / vector)
//            cas[2:0]            cascade ID bus (master drives)
//            int_o               interrupt request to CPU / master IR pin
// Config   : PIC_AUTO_ROTATE_EN  enables rotate-in-AEOI via OCW2 R=1,SL=0,EOI=0
// Revision : 1.0  initial release
// ============================================================================
module pic_8259a_core #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cs_n,
   input  logic       rd_n,
   input  logic       wr_n,
   input  logic       a0,
   input  logic       sp_en_n,
   input  logic       inta_n,
   input  logic [7:0] ir,
   inout  wire  [7:0] data,
   inout  wire  [2:0] cas,
   output logic       int_o
);
   typedef enum logic [2:0] {INIT_IDLE, INIT_ICW2, INIT_ICW3, INIT_ICW4, INIT_READY} init_t;
   typedef enum logic [2:0] {IA_IDLE, IA_P1, IA_P1W, IA_GAP, IA_P2, IA_IGN_GAP, IA_IGN_P2} ack_t;

   init_t init_st, init_nx;
   ack_t  ack_st, ack_nx;

   logic [7:0] ir_pipe  [SYNC_STAGES];
   logic [2:0] cas_pipe [SYNC_STAGES];
   logic [7:0] ir_s, ir_prev, data_s;
   logic [2:0] cas_s;
   logic       cs_s, rd_s, wr_s, wr_prev, inta_s, inta_prev, a0_s;

   logic [7:0] imr, irr, isr, icw3;
   logic [4:0] base;
   logic       ic4, sngl, ltim, aeoi, rd_isr, spur;
   logic [2:0] n, lp;

   // Input capture: ir/cas through a synchronizer chain, strobes and the
   // data/address lines through one sample flop so they stay aligned.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            ir_pipe[s]  <= '0;
            cas_pipe[s] <= '0;
         end
         cs_s <= 1'b1; rd_s <= 1'b1; wr_s <= 1'b1; wr_prev <= 1'b1;
         inta_s <= 1'b1; inta_prev <= 1'b1; a0_s <= 1'b0;
         data_s <= '0; ir_prev <= '0;
      end else begin
         ir_pipe[0]  <= ir;
         cas_pipe[0] <= cas;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            ir_pipe[s]  <= ir_pipe[s-1];
            cas_pipe[s] <= cas_pipe[s-1];
         end
         cs_s <= cs_n; rd_s <= rd_n; wr_s <= wr_n; wr_prev <= wr_s;
         inta_s <= inta_n; inta_prev <= inta_s; a0_s <= a0;
         data_s <= data; ir_prev <= ir_s;
      end
   end

   assign ir_s  = ir_pipe[SYNC_STAGES-1];
   assign cas_s = cas_pipe[SYNC_STAGES-1];

   logic wr_commit, is_icw1, is_ready, fall, rise, cascade_slave, master_cas;
   assign wr_commit     = wr_s & ~wr_prev & ~cs_s;
   assign is_icw1       = wr_commit & ~a0_s & data_s[4];
   assign is_ready      = (init_st == INIT_READY);
   assign fall          = inta_prev & ~inta_s;
   assign rise          = ~inta_prev & inta_s;
   assign cascade_slave = ~sp_en_n & ~sngl;
   assign master_cas    = sp_en_n & ~sngl;

   // Highest-priority set bit of v when 'low' is the lowest-priority level.
   // Scanning from lowest to highest rank leaves the best hit in r.
   function automatic logic [3:0] highest(input logic [7:0] v, input logic [2:0] low);
      logic [3:0] r;
      logic [2:0] idx;
      r = 4'd0;
      for (int k = 7; k >= 0; k--) begin
         idx = low + 3'd1 + 3'(k);
         if (v[idx]) r = {1'b1, idx};
      end
      return r;
   endfunction

   logic       p_found, s_found, outranks, spur_now;
   logic [2:0] p_idx, s_idx, p_rank, s_rank, n_now;
   assign {p_found, p_idx} = highest(irr & ~imr, lp);
   assign {s_found, s_idx} = highest(isr, lp);
   assign p_rank   = p_idx - lp - 3'd1;
   assign s_rank   = s_idx - lp - 3'd1;
   assign outranks = p_found & (~s_found | (p_rank < s_rank));
   assign spur_now = ~outranks;
   assign n_now    = outranks ? p_idx : 3'd7;

   // Initialization sequencer
   always_ff @(posedge clk) begin
      if (rst) init_st <= INIT_IDLE;
      else     init_st <= init_nx;
   end

   always_comb begin
      init_nx = init_st;
      if (is_icw1) begin
         init_nx = INIT_ICW2;
      end else if (wr_commit && a0_s) begin
         case (init_st)
            INIT_ICW2: init_nx = !sngl ? INIT_ICW3 : (ic4 ? INIT_ICW4 : INIT_READY);
            INIT_ICW3: init_nx = ic4 ? INIT_ICW4 : INIT_READY;
            INIT_ICW4: init_nx = INIT_READY;
            default:   init_nx = init_st;
         endcase
      end
   end

   // Acknowledge sequencer. A cascaded slave cannot judge cas at the falling
   // edge of pulse 1 (the master is only starting to drive it), so it decides
   // at the end of pulse 1 and either takes the sequence or ignores it.
   logic take, done;

   always_ff @(posedge clk) begin
      if (rst) ack_st <= IA_IDLE;
      else     ack_st <= ack_nx;
   end

   always_comb begin
      ack_nx = ack_st;
      take   = 1'b0;
      done   = 1'b0;
      case (ack_st)
         IA_IDLE: if (fall && is_ready) begin
            if (cascade_slave) ack_nx = IA_P1W;
            else begin ack_nx = IA_P1; take = 1'b1; end
         end
         IA_P1:      if (rise) ack_nx = IA_GAP;
         IA_P1W:     if (rise) begin
            if (cas_s == icw3[2:0]) begin ack_nx = IA_GAP; take = 1'b1; end
            else ack_nx = IA_IGN_GAP;
         end
         IA_GAP:     if (fall) ack_nx = IA_P2;
         IA_P2:      if (rise) begin ack_nx = IA_IDLE; done = 1'b1; end
         IA_IGN_GAP: if (fall) ack_nx = IA_IGN_P2;
         IA_IGN_P2:  if (rise) ack_nx = IA_IDLE;
         default:    ack_nx = IA_IDLE;
      endcase
      if (is_icw1) begin
         ack_nx = IA_IDLE;
         take   = 1'b0;
         done   = 1'b0;
      end
   end

`ifdef PIC_AUTO_ROTATE_EN
   logic rot_aeoi;
   always_ff @(posedge clk) begin
      if (rst || is_icw1) begin
         rot_aeoi <= 1'b0;
         lp       <= 3'd7;
      end else begin
         if (wr_commit && is_ready && !a0_s && !data_s[4] && !data_s[3]) begin
            if (data_s[7:5] == 3'b100)      rot_aeoi <= 1'b1;
            else if (data_s[7:5] == 3'b000) rot_aeoi <= 1'b0;
         end
         if (done && aeoi && rot_aeoi && !spur) lp <= n;
      end
   end
`else
   assign lp = 3'd7;
`endif

   // Register file, request/service bookkeeping and int_o
   always_ff @(posedge clk) begin
      if (rst) begin
         imr <= '0; irr <= '0; isr <= '0; icw3 <= '0; base <= '0;
         ic4 <= 1'b0; sngl <= 1'b1; ltim <= 1'b0; aeoi <= 1'b0;
         rd_isr <= 1'b0; n <= 3'd7; spur <= 1'b1; int_o <= 1'b0;
      end else begin
         irr   <= ltim ? ir_s : (irr | (ir_s & ~ir_prev));
         int_o <= is_ready & outranks;
         if (take) begin
            n    <= n_now;
            spur <= spur_now;
            if (!spur_now) begin
               isr[n_now] <= 1'b1;
               irr[n_now] <= 1'b0;
            end
         end
         if (done && aeoi && !spur) isr[n] <= 1'b0;
         if (is_icw1) begin
            imr <= '0; isr <= '0; irr <= '0;
            ic4 <= data_s[0]; sngl <= data_s[1]; ltim <= data_s[3];
            aeoi <= 1'b0; rd_isr <= 1'b0; int_o <= 1'b0;
         end else if (wr_commit) begin
            case (init_st)
               INIT_ICW2: if (a0_s) base <= data_s[7:3];
               INIT_ICW3: if (a0_s) icw3 <= data_s;
               INIT_ICW4: if (a0_s) aeoi <= data_s[1];
               INIT_READY: begin
                  if (a0_s) imr <= data_s;
                  else if (!data_s[3]) begin
                     if (data_s[5]) begin
                        if (data_s[6])    isr[data_s[2:0]] <= 1'b0;
                        else if (s_found) isr[s_idx] <= 1'b0;
                     end
                  end else if (data_s[1]) begin
                     rd_isr <= data_s[0];
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Bus drivers. A master whose winner has a slave leaves the vector to it.
   logic       vec_oe, read_oe;
   logic [7:0] data_out;
   logic [2:0] cas_out;
   assign vec_oe   = (ack_st == IA_P2) & ~inta_s & ~(master_cas & icw3[n] & ~spur);
   assign read_oe  = ~cs_s & ~rd_s & (ack_st == IA_IDLE) & inta_s;
   assign data_out = vec_oe ? {base, n} : (a0_s ? imr : (rd_isr ? isr : irr));
   assign cas_out  = ((ack_st == IA_P1 || ack_st == IA_GAP || ack_st == IA_P2)
                      && icw3[n] && !spur) ? n : 3'd0;

   assign data = (vec_oe | read_oe) ? data_out : 8'hzz;
   assign cas  = master_cas ? cas_out : 3'bzzz;
endmodule
`default_nettype wire

// File: tb/tb_pic_8259a_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_pic_8259a_core
// Purpose  : Self-checking bench: one master and two cascaded slaves sharing
//            data/cas/inta. Directed steps plus a randomized single-mode phase
//            checked against a priority model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pic_8259a_core;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, rd_n, wr_n, a0, inta_n, cs_m, cs_0, cs_5, casc, tb_oe;
   logic [7:0] ir_tb, ir_s0, ir_s5, ir_m, tb_d;
   logic       int_m, int_0, int_5;
   wire  [7:0] data_bus;
   wire  [2:0] cas_bus;

   assign data_bus = tb_oe ? tb_d : 8'hzz;
   assign ir_m     = casc ? {ir_tb[7:6], int_5, ir_tb[4:1], int_0} : ir_tb;

   pic_8259a_core u_master (.clk(clk), .rst(rst), .cs_n(cs_m), .rd_n(rd_n), .wr_n(wr_n),
      .a0(a0), .sp_en_n(1'b1), .inta_n(inta_n), .ir(ir_m), .data(data_bus),
      .cas(cas_bus), .int_o(int_m));
   pic_8259a_core u_slave0 (.clk(clk), .rst(rst), .cs_n(cs_0), .rd_n(rd_n), .wr_n(wr_n),
      .a0(a0), .sp_en_n(1'b0), .inta_n(inta_n), .ir(ir_s0), .data(data_bus),
      .cas(cas_bus), .int_o(int_0));
   pic_8259a_core u_slave5 (.clk(clk), .rst(rst), .cs_n(cs_5), .rd_n(rd_n), .wr_n(wr_n),
      .a0(a0), .sp_en_n(1'b0), .inta_n(inta_n), .ir(ir_s5), .data(data_bus),
      .cas(cas_bus), .int_o(int_5));

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $display("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
         $error("%s", tag);
      end
   endtask

   task automatic sel(input int chip);
      cs_m = (chip != 0);
      cs_0 = (chip != 1);
      cs_5 = (chip != 2);
   endtask

   task automatic wr(input int chip, input logic a, input logic [7:0] d);
      @(posedge clk); #1;
      sel(chip); a0 = a; tb_d = d; tb_oe = 1'b1; wr_n = 1'b0;
      repeat (4) @(posedge clk);
      #1 wr_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 sel(3); tb_oe = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic rd(input int chip, input logic a, output logic [7:0] d);
      @(posedge clk); #1;
      sel(chip); a0 = a; rd_n = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk); d = data_bus;
      @(posedge clk); #1 rd_n = 1'b1; sel(3);
      repeat (3) @(posedge clk);
   endtask

   task automatic inta(output logic [7:0] vec, output logic [2:0] c1, output logic [2:0] c2);
      @(posedge clk); #1 inta_n = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk); c1 = cas_bus;
      @(posedge clk); #1 inta_n = 1'b1;
      repeat (8) @(posedge clk);
      #1 inta_n = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk); vec = data_bus; c2 = cas_bus;
      @(posedge clk); #1 inta_n = 1'b1;
      repeat (6) @(posedge clk);
   endtask

   task automatic chk_int(input string tag, input logic exp);
      @(negedge clk);
      check(tag, {7'd0, int_m}, {7'd0, exp});
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] v, vec, base, imr_m, irp, pend;
      logic [2:0] c1, c2, exp_n;

      rst = 1'b1; rd_n = 1'b1; wr_n = 1'b1; a0 = 1'b0; inta_n = 1'b1;
      sel(3); casc = 1'b0; tb_oe = 1'b0; tb_d = 8'h00;
      ir_tb = 8'h00; ir_s0 = 8'h00; ir_s5 = 8'h00;
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);

      // Reset state
      chk_int("rst_int", 1'b0);
      rd(0, 1'b1, v); check("rst_imr", v, 8'h00);
      rd(0, 1'b0, v); check("rst_irr", v, 8'h00);

      // Master init, cascade, level, AEOI
      wr(0, 1'b0, 8'h19); wr(0, 1'b1, 8'hE8); wr(0, 1'b1, 8'h21); wr(0, 1'b1, 8'h03);
      chk_int("init_int", 1'b0);
      rd(0, 1'b1, v); check("init_imr", v, 8'h00);

      // Master-level request on ir[1]
      ir_tb = 8'h02;
      repeat (6) @(posedge clk);
      chk_int("ir1_int", 1'b1);
      inta(vec, c1, c2);
      check("ir1_vec", vec, 8'hE9);
      check("ir1_cas1", {5'd0, c1}, 8'h00);
      check("ir1_cas2", {5'd0, c2}, 8'h00);
      ir_tb = 8'h00;
      repeat (6) @(posedge clk);
      wr(0, 1'b0, 8'h0B);
      rd(0, 1'b0, v); check("ir1_isr_aeoi", v, 8'h00);

      // Masking
      wr(0, 1'b1, 8'h02);
      ir_tb = 8'h02;
      repeat (6) @(posedge clk);
      chk_int("mask_int", 1'b0);
      wr(0, 1'b1, 8'h00);
      chk_int("unmask_int", 1'b1);
      ir_tb = 8'h00;
      repeat (6) @(posedge clk);

      // Normal EOI
      wr(0, 1'b0, 8'h19); wr(0, 1'b1, 8'hE8); wr(0, 1'b1, 8'h21); wr(0, 1'b1, 8'h01);
      ir_tb = 8'h08;
      repeat (6) @(posedge clk);
      inta(vec, c1, c2);
      check("eoi_vec", vec, 8'hEB);
      ir_tb = 8'h00;
      repeat (6) @(posedge clk);
      wr(0, 1'b0, 8'h0B);
      rd(0, 1'b0, v); check("eoi_isr_set", v, 8'h08);
      wr(0, 1'b0, 8'h20);
      rd(0, 1'b0, v); check("eoi_isr_clr", v, 8'h00);

      // Edge mode: a held request is acknowledged once, then spurious
      wr(0, 1'b0, 8'h11); wr(0, 1'b1, 8'hE8); wr(0, 1'b1, 8'h21); wr(0, 1'b1, 8'h03);
      ir_tb = 8'h02;
      repeat (6) @(posedge clk);
      chk_int("edge_int", 1'b1);
      inta(vec, c1, c2);
      check("edge_vec1", vec, 8'hE9);
      chk_int("edge_int_after", 1'b0);
      inta(vec, c1, c2);
      check("edge_spurious", vec, 8'hEF);
      ir_tb = 8'h00;
      repeat (6) @(posedge clk);

      // Randomized single-mode phase against a fixed-priority model
      wr(0, 1'b0, 8'h1B);
      base = 8'($urandom) & 8'hF8;
      wr(0, 1'b1, base); wr(0, 1'b1, 8'h03);
      for (int it = 0; it < 10; it++) begin
         imr_m = (it == 0) ? 8'hFF : 8'($urandom);
         irp   = (it == 1) ? 8'h81 : 8'($urandom);
         wr(0, 1'b1, imr_m);
         ir_tb = irp;
         repeat (6) @(posedge clk);
         pend  = irp & ~imr_m;
         exp_n = 3'd7;
         for (int b = 7; b >= 0; b--) if (pend[b]) exp_n = 3'(b);
         chk_int("rnd_int", pend != 8'h00);
         rd(0, 1'b0, v); check("rnd_irr", v, irp);
         rd(0, 1'b1, v); check("rnd_imr", v, imr_m);
         inta(vec, c1, c2);
         check("rnd_vec", vec, base | {5'd0, exp_n});
         ir_tb = 8'h00;
         repeat (6) @(posedge clk);
      end

      // Cascade: slave0 (ID 0, 0xC8) and slave5 (ID 5, 0x88)
      wr(1, 1'b0, 8'h11); wr(1, 1'b1, 8'hC8); wr(1, 1'b1, 8'h00); wr(1, 1'b1, 8'h03);
      wr(2, 1'b0, 8'h11); wr(2, 1'b1, 8'h88); wr(2, 1'b1, 8'h05); wr(2, 1'b1, 8'h03);
      casc = 1'b1;
      wr(0, 1'b0, 8'h19); wr(0, 1'b1, 8'hE8); wr(0, 1'b1, 8'h21); wr(0, 1'b1, 8'h03);
      ir_s0 = 8'h01; ir_s5 = 8'h01;
      repeat (10) @(posedge clk);
      chk_int("casc_int", 1'b1);
      inta(vec, c1, c2);
      check("casc1_cas", {5'd0, c1}, 8'h00);
      check("casc1_vec", vec, 8'hC8);
      inta(vec, c1, c2);
      check("casc2_cas1", {5'd0, c1}, 8'h05);
      check("casc2_cas2", {5'd0, c2}, 8'h05);
      check("casc2_vec", vec, 8'h88);
      chk_int("casc_int_done", 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
